// File: rtl/gem_link_pkg.sv
// Shared constants and types for the GEM trigger-fiber link framer.
// K-codes, idle comma pattern, link state encoding and PRBS-31 taps.
package gem_link_pkg;

    localparam logic [7:0] K_BC = 8'hBC;
    localparam logic [7:0] K_F7 = 8'hF7;
    localparam logic [7:0] K_FB = 8'hFB;
    localparam logic [7:0] K_FD = 8'hFD;
    localparam logic [7:0] K_FC = 8'hFC;

    localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_ISK  = 4'b0101;

    typedef enum logic [1:0] {
        LS_IDLE  = 2'b00,
        LS_ALIGN = 2'b01,
        LS_RUN   = 2'b10
    } link_state_t;

    // x^31 + x^28 + 1: feedback from the two oldest-but-three bits of the shift register
    localparam int              PRBS_LEN    = 31;
    localparam int              PRBS_TAP_HI = 30;
    localparam int              PRBS_TAP_LO = 27;
    localparam logic [30:0]     PRBS_SEED   = 31'h7FFFFFFF;

    function automatic logic [7:0] sep_code(input logic [1:0] slot);
        logic [7:0] code;
        case (slot)
            2'd0:    code = K_BC;
            2'd1:    code = K_F7;
            2'd2:    code = K_FB;
            2'd3:    code = K_FD;
            default: code = K_BC;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gem_prbs_gen.sv
// Parallel PRBS-31 generator: presents the next OUT_W sequence bits (first bit in
// the MSB) and jumps the register OUT_W steps ahead when advanced.
module gem_prbs_gen
    import gem_link_pkg::*;
#(
    parameter int OUT_W = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    output logic [OUT_W-1:0] prbs_o
);

    logic [PRBS_LEN-1:0] lfsr_q;
    logic [PRBS_LEN-1:0] lfsr_d;
    logic [PRBS_LEN-1:0] walk_s;
    logic [OUT_W-1:0]    bits_s;
    logic                fb_s;

    // Unroll OUT_W serial shifts to get both the output word and the jumped-ahead state
    always_comb begin
        walk_s = lfsr_q;
        bits_s = '0;
        fb_s   = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            fb_s                = walk_s[PRBS_TAP_HI] ^ walk_s[PRBS_TAP_LO];
            bits_s[OUT_W-1-i]   = fb_s;
            walk_s              = {walk_s[PRBS_LEN-2:0], fb_s};
        end
    end

    // Next-state selection: reseed has priority over advance
    always_comb begin
        if (load) begin
            lfsr_d = PRBS_SEED;
        end else if (adv) begin
            lfsr_d = walk_s;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= PRBS_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign prbs_o = bits_s;

endmodule

// File: rtl/gem_link_framer.sv
// GEM trigger-fiber transmit framer: start-up FSM (idle/align/run), payload plus
// rotating K-code separator packed into FRAME_WORDS GTX words, PRBS test mode.
module gem_link_framer
    import gem_link_pkg::*;
#(
    parameter int DATA_W       = 56,
    parameter int FRAME_WORDS  = 2,
    parameter int SEP_HOLD     = 2,
    parameter int ALIGN_FRAMES = 16,
    parameter int CNT_W        = 16
) (
    input  logic              TRG_CLK80,
    input  logic              TRG_TXRESETDONE,
    input  logic              TRG_RST,
    input  logic              TX_SYNC_DONE,
    input  logic              ENA_TEST_PAT,
    input  logic              INJ_ERR,
    input  logic [DATA_W-1:0] GEM_DATA,
    input  logic              GEM_OVERFLOW,
    output logic [31:0]       TX_DATA,
    output logic [3:0]        TX_ISK,
    output logic              FRAME_START,
    output logic              LINK_READY,
    output logic [1:0]        LINK_STATE,
    output logic [CNT_W-1:0]  FRAME_CNT
);

    localparam int               FRAME_W    = 32 * FRAME_WORDS;
    localparam int               IDX_W      = 2;
    localparam int               ROT_W      = 5;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FRAME_WORDS - 1);
    localparam logic [ROT_W-1:0] ROT_LAST   = ROT_W'(4 * SEP_HOLD - 1);
    localparam logic [7:0]       ALIGN_LAST = 8'(ALIGN_FRAMES - 1);

    link_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         align_cnt_q, align_cnt_d;
    logic [ROT_W-1:0]   rot_q, rot_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [31:0]        tx_data_q, tx_data_d;
    logic [3:0]         tx_isk_q, tx_isk_d;
    logic               frame_start_q, frame_start_d;
    logic               link_ready_q, link_ready_d;
    logic               inj_sync_q, inj_sync_d;
    logic               inj_prev_q, inj_prev_d;
    logic               inj_pend_q, inj_pend_d;

    logic               boundary_s;
    logic               abort_s;
    logic               capture_s;
    logic               inj_rise_s;
    logic [1:0]         slot_s;
    logic [7:0]         sep_s;
    logic [DATA_W-1:0]  payload_s;
    logic [DATA_W-1:0]  prbs_word_s;
    logic [FRAME_W-1:0] frame_new_s;
    logic [FRAME_W-1:0] word_src_s;
    logic [31:0]        tx_word_s;
    logic               prbs_load_s;
    logic               prbs_adv_s;

    // Link FSM, frame assembly and output word selection
    always_comb begin
        inj_sync_d  = INJ_ERR;
        inj_prev_d  = inj_sync_q;
        inj_rise_s  = inj_sync_q & ~inj_prev_q;

        boundary_s  = (idx_q == IDX_LAST);
        idx_d       = boundary_s ? '0 : idx_q + 2'd1;
        abort_s     = TRG_RST | ~TX_SYNC_DONE;

        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        capture_s   = 1'b0;
        case (state_q)
            LS_IDLE: begin
                if (boundary_s && !abort_s) begin
                    state_d = LS_ALIGN;
                end else begin
                    state_d = LS_IDLE;
                end
            end
            LS_ALIGN: begin
                if (abort_s) begin
                    state_d = LS_IDLE;
                end else if (boundary_s && (align_cnt_q == ALIGN_LAST)) begin
                    state_d   = LS_RUN;
                    capture_s = 1'b1;
                end else if (boundary_s) begin
                    align_cnt_d = align_cnt_q + 8'd1;
                end else begin
                    align_cnt_d = align_cnt_q;
                end
            end
            LS_RUN: begin
                if (abort_s) begin
                    state_d = LS_IDLE;
                end else if (boundary_s) begin
                    capture_s = 1'b1;
                end else begin
                    state_d = LS_RUN;
                end
            end
            default: begin
                state_d = LS_IDLE;
            end
        endcase
        align_cnt_d = (state_d == LS_ALIGN) ? align_cnt_d : 8'd0;

        // Overflow overrides the code but the rotation position still moves on
        payload_s    = ENA_TEST_PAT ? prbs_word_s : GEM_DATA;
        payload_s[0] = payload_s[0] ^ inj_pend_q;
        slot_s       = 2'(int'(rot_q) / SEP_HOLD);
        sep_s        = GEM_OVERFLOW ? K_FC : sep_code(slot_s);
        frame_new_s  = '0;
        frame_new_s[FRAME_W-1 -: DATA_W] = payload_s;
        frame_new_s[7:0]                 = sep_s;

        frame_d     = capture_s ? frame_new_s : frame_q;
        inj_pend_d  = capture_s ? inj_rise_s : (inj_pend_q | inj_rise_s);
        rot_d       = (state_d != LS_RUN) ? '0 :
                      (capture_s ? ((rot_q == ROT_LAST) ? '0 : rot_q + 5'd1) : rot_q);
        frame_cnt_d = (state_d != LS_RUN) ? '0 :
                      (capture_s ? frame_cnt_q + CNT_W'(1) : frame_cnt_q);

        // Word 0 of a new frame comes straight from the capture path
        word_src_s = capture_s ? frame_new_s : frame_q;
        tx_word_s  = '0;
        for (int k = 0; k < FRAME_WORDS; k++) begin
            tx_word_s = (idx_d == IDX_W'(k)) ? word_src_s[FRAME_W-1-32*k -: 32] : tx_word_s;
        end

        if (state_d == LS_RUN) begin
            tx_data_d = tx_word_s;
            tx_isk_d  = (idx_d == IDX_LAST) ? 4'b0001 : 4'b0000;
        end else begin
            tx_data_d = IDLE_WORD;
            tx_isk_d  = IDLE_ISK;
        end
        frame_start_d = (idx_d == '0);
        link_ready_d  = (state_d == LS_RUN);

        prbs_load_s = (state_d != LS_RUN);
        prbs_adv_s  = capture_s & ENA_TEST_PAT;
    end

    // State and output registers
    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            state_q       <= LS_IDLE;
            idx_q         <= '0;
            align_cnt_q   <= 8'd0;
            rot_q         <= '0;
            frame_cnt_q   <= '0;
            frame_q       <= '0;
            tx_data_q     <= IDLE_WORD;
            tx_isk_q      <= IDLE_ISK;
            frame_start_q <= 1'b0;
            link_ready_q  <= 1'b0;
            inj_sync_q    <= 1'b0;
            inj_prev_q    <= 1'b0;
            inj_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            align_cnt_q   <= align_cnt_d;
            rot_q         <= rot_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_q       <= frame_d;
            tx_data_q     <= tx_data_d;
            tx_isk_q      <= tx_isk_d;
            frame_start_q <= frame_start_d;
            link_ready_q  <= link_ready_d;
            inj_sync_q    <= inj_sync_d;
            inj_prev_q    <= inj_prev_d;
            inj_pend_q    <= inj_pend_d;
        end
    end

    gem_prbs_gen #(
        .OUT_W (DATA_W)
    ) u_prbs (
        .clk    (TRG_CLK80),
        .rst_n  (TRG_TXRESETDONE),
        .load   (prbs_load_s),
        .adv    (prbs_adv_s),
        .prbs_o (prbs_word_s)
    );

    assign TX_DATA     = tx_data_q;
    assign TX_ISK      = tx_isk_q;
    assign FRAME_START = frame_start_q;
    assign LINK_READY  = link_ready_q;
    assign LINK_STATE  = state_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_gem_link_framer.sv
// Directed plus randomized bench for gem_link_framer; expected frames come from a
// bitstream-level PRBS model and the framing rules applied per captured frame.
module tb_gem_link_framer;

    localparam int DW = 56;
    localparam int FW = 2;
    localparam int SH = 2;
    localparam int AF = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          trg_rst;
    logic          sync;
    logic          ena;
    logic          inj;
    logic [DW-1:0] gem;
    logic          ovf;
    logic [31:0]   tx_data;
    logic [3:0]    tx_isk;
    logic          fstart;
    logic          ready;
    logic [1:0]    lstate;
    logic [CW-1:0] fcnt;

    always #6 clk = ~clk;

    gem_link_framer #(
        .DATA_W(DW), .FRAME_WORDS(FW), .SEP_HOLD(SH), .ALIGN_FRAMES(AF), .CNT_W(CW)
    ) dut (
        .TRG_CLK80      (clk),
        .TRG_TXRESETDONE(rstn),
        .TRG_RST        (trg_rst),
        .TX_SYNC_DONE   (sync),
        .ENA_TEST_PAT   (ena),
        .INJ_ERR        (inj),
        .GEM_DATA       (gem),
        .GEM_OVERFLOW   (ovf),
        .TX_DATA        (tx_data),
        .TX_ISK         (tx_isk),
        .FRAME_START    (fstart),
        .LINK_READY     (ready),
        .LINK_STATE     (lstate),
        .FRAME_CNT      (fcnt)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    bit         inj_last = 1'b0;
    int         rises[$];
    bit         pb[$];
    int         ppos;
    int         seq_n;
    int         cnt_m;
    logic [7:0] seps_seen[$];
    logic [7:0] rot_tab [4]  = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};
    logic [7:0] exp_seps [10] = '{8'hBC, 8'hBC, 8'hFC, 8'hF7, 8'hFB,
                                  8'hFB, 8'hFD, 8'hFD, 8'hBC, 8'hBC};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; records INJ_ERR rising edges as sampled by the DUT
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (inj && !inj_last) rises.push_back(cyc);
        inj_last = inj;
        #1;
    endtask

    task automatic model_reset();
        pb.delete();
        for (int i = 0; i < 31; i++) pb.push_back(1'b1);
        ppos  = 0;
        seq_n = 0;
        cnt_m = 0;
    endtask

    // Next DW bits of the PRBS-31 bitstream b[n] = b[n-31] ^ b[n-28], seed all ones
    task automatic prbs_take(output logic [DW-1:0] p);
        while (pb.size() < 31 + ppos + DW) pb.push_back(pb[pb.size()-31] ^ pb[pb.size()-28]);
        for (int i = 0; i < DW; i++) p[DW-1-i] = pb[31 + ppos + i];
        ppos += DW;
    endtask

    task automatic wait_align();
        int n = 0;
        bit first = 1'b1;
        for (int t = 0; t < 400 && n < AF * FW; t++) begin
            tick();
            chk("idle_data", tx_data, 32'h50BC50BC);
            chk("idle_isk", tx_isk, 4'b0101);
            if (lstate == 2'b01) begin
                if (first) chk("align_at_boundary", fstart, 1'b1);
                first = 1'b0;
                n++;
            end else begin
                chk("pre_align_state", lstate, 2'b00);
            end
        end
        chk("align_words", n, AF * FW);
    endtask

    // Precondition: next edge is a frame boundary. abort: 1 = TRG_RST, 2 = sync drop, after word 0
    task automatic do_frame(input logic [DW-1:0] d, input logic o, input logic e,
                            input bit pulse, input int abort);
        logic [FW*32-1:0] f;
        logic [DW-1:0]    p;
        logic [7:0]       sep;
        bit               err;
        gem = d;
        ovf = o;
        ena = e;
        if (pulse) inj = 1'b1;
        tick();
        err = 1'b0;
        for (int i = rises.size() - 1; i >= 0; i--) begin
            if (rises[i] + 2 <= cyc) begin
                err = 1'b1;
                rises.delete(i);
            end
        end
        if (e) prbs_take(p);
        else p = d;
        if (err) p[0] = ~p[0];
        sep = o ? 8'hFC : rot_tab[(seq_n / SH) % 4];
        seq_n++;
        cnt_m = (cnt_m + 1) % (1 << CW);
        f = '0;
        f[FW*32-1 -: DW] = p;
        f[7:0] = sep;
        inj = 1'b0;
        for (int k = 0; k < FW; k++) begin
            if (k != 0) tick();
            chk("word", tx_data, f[FW*32-1-32*k -: 32]);
            chk("isk", tx_isk, (k == FW - 1) ? 4'b0001 : 4'b0000);
            chk("frame_start", fstart, (k == 0) ? 1'b1 : 1'b0);
            chk("state_run", lstate, 2'b10);
            if (k == 0) begin
                chk("frame_cnt", fcnt, cnt_m);
                chk("link_ready", ready, 1'b1);
                gem = DW'({$urandom, $urandom});
                ovf = 1'($urandom);
                ena = 1'($urandom);
                if (abort != 0) begin
                    if (abort == 1) trg_rst = 1'b1;
                    else sync = 1'b0;
                    tick();
                    chk("abort_data", tx_data, 32'h50BC50BC);
                    chk("abort_isk", tx_isk, 4'b0101);
                    chk("abort_state", lstate, 2'b00);
                    chk("abort_ready", ready, 1'b0);
                    chk("abort_cnt", fcnt, 0);
                    return;
                end
            end
            if (k == FW - 1) seps_seen.push_back(tx_data[7:0]);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        trg_rst = 1'b0;
        sync    = 1'b0;
        ena     = 1'b0;
        inj     = 1'b0;
        ovf     = 1'b0;
        gem     = 56'h123456789ABCDE;
        #20;
        chk("rst_data", tx_data, 32'h50BC50BC);
        chk("rst_isk", tx_isk, 4'b0101);
        chk("rst_fstart", fstart, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_state", lstate, 2'b00);
        chk("rst_cnt", fcnt, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_nosync_data", tx_data, 32'h50BC50BC);
            chk("idle_nosync_state", lstate, 2'b00);
        end
        sync = 1'b1;
        wait_align();
        model_reset();

        do_frame(56'h123456789ABCDE, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i < 10; i++) do_frame(DW'({$urandom, $urandom}), (i == 2), 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) chk("sep_sequence", seps_seen[i], exp_seps[i]);
        chk("frame_cnt_10", fcnt, 10);

        for (int i = 0; i < 8; i++)
            do_frame(DW'({$urandom, $urandom}), ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 0);

        for (int i = 0; i < 3; i++) do_frame(DW'({$urandom, $urandom}), 1'b0, 1'b1, 1'b0, 0);
        do_frame(DW'({$urandom, $urandom}), 1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) do_frame(DW'({$urandom, $urandom}), 1'b0, 1'b1, 1'b0, 0);

        for (int i = 0; i < 16; i++)
            do_frame(DW'({$urandom, $urandom}), ($urandom_range(0, 3) == 0),
                     1'($urandom), ($urandom_range(0, 4) == 0), 0);

        do_frame(DW'({$urandom, $urandom}), 1'b0, 1'b1, 1'b0, 1);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("rst_hold_state", lstate, 2'b00);
        trg_rst = 1'b0;
        model_reset();
        wait_align();
        for (int i = 0; i < 4; i++) do_frame(DW'({$urandom, $urandom}), 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk("reentry_sep", seps_seen[seps_seen.size()-4+i], rot_tab[i / SH]);

        do_frame(DW'({$urandom, $urandom}), 1'b0, 1'b0, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gem_link_framer.md
Name: gem_link_framer

Overview:
- Parametrised successor to the GEM trigger-fiber transmit data path.
- Packs a DATA_W-bit GEM cluster word plus an 8-bit K-code frame separator into FRAME_WORDS consecutive 32-bit GTX words per bunch.
- Adds a link start-up state machine (idle commas, alignment burst, run), configurable separator rotation, a frame counter and a single-shot PRBS error injector.
- Sits between the cluster packer and the GTX TX wrapper, which it drives through TX_DATA and TX_ISK.

Parameters:
- DATA_W, 56: payload width. Constraint: DATA_W+8 <= 32*FRAME_WORDS.
- FRAME_WORDS, 2: 32-bit words per frame. Range 2..4.
- SEP_HOLD, 2: consecutive frames that carry each rotating K-code. Range 1..8.
- ALIGN_FRAMES, 16: comma frames sent after TX_SYNC_DONE before data. Range 1..255.
- CNT_W, 16: FRAME_CNT width.

Ports:
- TRG_CLK80  in  1  TX user clock 2 (80 MHz).
- TRG_TXRESETDONE  in  1  reset, asynchronous, active-low. Clock is TRG_CLK80.
- TRG_RST  in  1  synchronous soft link reset, active-high.
- TX_SYNC_DONE  in  1  GTX phase alignment complete.
- ENA_TEST_PAT  in  1  1 = send PRBS payload, 0 = send GEM_DATA.
- INJ_ERR  in  1  level input; its rising edge injects one bit error.
- GEM_DATA  in  DATA_W  cluster payload.
- GEM_OVERFLOW  in  1  S-bit overflow flag.
- TX_DATA  out  32  GTX TXDATA.
- TX_ISK  out  4  GTX TXCHARISK.
- FRAME_START  out  1  high on the cycle TX_DATA carries word 0.
- LINK_READY  out  1  high in RUN state.
- LINK_STATE  out  2  00 IDLE, 01 ALIGN, 10 RUN.
- FRAME_CNT  out  CNT_W  count of data frames sent in RUN; wraps.

Behaviour:
- Reset (TRG_TXRESETDONE low, asynchronous) forces:
  - TX_DATA=32'h50BC50BC, TX_ISK=4'b0101
  - FRAME_START=0, LINK_READY=0, LINK_STATE=IDLE, FRAME_CNT=0
  - word index=0, separator counter=0, PRBS LFSR=all ones.
- All outputs are registered.
- Word index counts 0..FRAME_WORDS-1 and wraps. It free-runs in every state, so frame boundaries are always defined.
- IDLE:
  - Output is 32'h50BC50BC, ISK 0101 on every word.
  - Transition to ALIGN on the first frame boundary (index wraps to 0) where TX_SYNC_DONE=1 and TRG_RST=0.
- ALIGN:
  - Each frame is words 32'h50BC50BC, ISK 0101.
  - An alignment counter counts frames. After ALIGN_FRAMES complete frames, go to RUN at the next boundary.
- RUN:
  - At each frame boundary, capture payload P: GEM_DATA, or the PRBS word if ENA_TEST_PAT=1. Capture SEP and advance the rotation.
  - Frame vector F = {P, zero pad, SEP}.
  - Word k = F[32*(FRAME_WORDS-1-k) +: 32], so word 0 carries the MSBs.
  - The last word has ISK 4'b0001. All other words have ISK 4'b0000.
  - Latency: GEM_DATA sampled at the boundary edge appears as word 0 one cycle later.
- Separator:
  - The rotation counter is zeroed on entry to RUN.
  - SEP = BC, F7, FB, FD, each held SEP_HOLD frames, then the sequence wraps.
  - If GEM_OVERFLOW=1 at the capture edge, SEP=FC. The rotation still advances, so the sequence position is preserved.
- FRAME_CNT:
  - Increments at each RUN frame capture and wraps at 2^CNT_W.
  - Cleared on leaving RUN.
- PRBS:
  - PRBS-31 (x^31+x^28+1), seed 31'h7FFFFFFF.
  - Advances DATA_W bits per frame only in RUN with ENA_TEST_PAT=1.
  - Reseeded whenever the state is not RUN.
- INJ_ERR:
  - A rising edge is detected with a 1-cycle synchroniser and sets a pending flag.
  - The next captured frame has payload bit 0 inverted, then the flag clears.
  - The LFSR sequence itself is not altered.
  - Any number of edges before the capture count as a single error.
- TRG_RST=1 in any state: the next cycle goes to IDLE, with commas on the very next word (mid-frame abort allowed). The word index is not reset.
- TX_SYNC_DONE falling in ALIGN or RUN acts the same as TRG_RST.
- Changing ENA_TEST_PAT mid-RUN takes effect at the next frame boundary.

Decomposition:
- Package gem_link_pkg holds:
  - K-code constants BC/F7/FB/FD/FC
  - IDLE_WORD 32'h50BC50BC, IDLE_ISK 4'b0101
  - link_state_t encoding
  - PRBS polynomial taps.
- One sub-module, gem_prbs_gen: parametrised parallel LFSR with inputs clock, reset, seed load and advance, and an output of width DATA_W.

Test Plan:
- Reset, then TX_SYNC_DONE=1 at cycle 10 (defaults) -> IDLE words until the boundary, 32 commas in ALIGN, then LINK_READY=1 and LINK_STATE=10.
- RUN, GEM_DATA=56'h123456789ABCDE, no overflow -> word0 32'h12345678 ISK 0000; word1 32'h9ABCDEBC ISK 0001; FRAME_START on word0.
- 10 consecutive frames -> separators BC,BC,F7,F7,FB,FB,FD,FD,BC,BC.
- GEM_OVERFLOW=1 on frame 3 only -> separator FC, frame 4 separator F7; FRAME_CNT=10 after 10 frames.
- ENA_TEST_PAT=1, INJ_ERR pulsed twice within one frame -> payload matches the PRBS-31 model except exactly one frame with bit 0 inverted; the following frame matches the model.
- TRG_RST during word1 of a RUN frame -> next TX_DATA 32'h50BC50BC ISK 0101, FRAME_CNT=0; re-entry to RUN restarts separators at BC and PRBS from the seed.
